// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with a byte-wide receive/transmit interface.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the sticky rx_ovr output.
//
// Receive handshake: rx_valid is a level that rises when a byte lands in
// data_out and stays high until the consumer pulses rx_ack for one cycle while
// rx_valid=1. A byte completing in the same cycle as rx_ack wins, so rx_valid
// stays high and data_out carries the new byte. A byte completing while
// rx_valid=1 overwrites data_out.
//
// fsm_state exposes the internal state register (WAIT_HI=0, IDLE=1, SHIFT=2).
module spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic [7:0] data_out,
   output logic       rx_valid,
   input  logic       rx_ack,
`ifdef SPI_SLAVE_OVERRUN_EN
   output logic       rx_ovr,
`endif
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      WAIT_HI = 2'd0,
      IDLE    = 2'd1,
      SHIFT   = 2'd2
   } state_t;

   // Cycles after reset before the synchroniser outputs hold real pin values
   // rather than their reset values.
   localparam logic [1:0] SETTLE_CYCLES = 2'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] scl_sync_q, cs_sync_q, mosi_sync_q;
   logic                   scl_prev_q;
   logic                   scl_s, cs_s, mosi_s;
   logic                   scl_rise, scl_fall;

   state_t      state_q, state_d;
   logic [1:0]  settle_q, settle_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [6:0]  rx_sr_q, rx_sr_d;
   logic [7:0]  tx_sr_q, tx_sr_d;
   logic [7:0]  tx_buf_q, tx_buf_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        rx_valid_q, rx_valid_d;
   logic        ovr_q, ovr_d;
   logic        byte_done;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;

   // Synchronisers for the asynchronous SPI pins plus the previous scl sample.
   always_ff @(posedge clk) begin
      if (!rst) begin
         scl_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         scl_prev_q  <= 1'b0;
      end else begin
         scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         scl_prev_q  <= scl_s;
      end
   end

   // Next-state logic for the frame FSM, shift registers and receive flags.
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      cnt_d      = cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      data_out_d = data_out_q;
      byte_done  = 1'b0;
      tx_buf_d   = tx_load ? tx_data : tx_buf_q;

      if (settle_q != SETTLE_CYCLES) settle_d = settle_q + 2'd1;

      case (state_q)
         // Only leave WAIT_HI once cs has genuinely been seen high, so a
         // frame interrupted by reset is never picked up half way.
         WAIT_HI: begin
            if ((settle_q == SETTLE_CYCLES) && cs_s) state_d = IDLE;
         end
         IDLE: begin
            if (!cs_s) begin
               state_d = SHIFT;
               tx_sr_d = tx_buf_q;
               cnt_d   = 3'd0;
            end
         end
         SHIFT: begin
            if (cs_s) begin
               // Frame end or abort; any partial byte is dropped.
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (scl_rise) begin
               rx_sr_d = {rx_sr_q[5:0], mosi_s};
               if (cnt_q == 3'd7) begin
                  cnt_d      = 3'd0;
                  data_out_d = {rx_sr_q, mosi_s};
                  byte_done  = 1'b1;
                  tx_sr_d    = tx_buf_q;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end else if (scl_fall && (cnt_q != 3'd0)) begin
               // A zero count here means the byte just wrapped and the freshly
               // loaded bit 7 must stay on miso.
               tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
         end
         default: state_d = WAIT_HI;
      endcase

      rx_valid_d = rx_valid_q;
      ovr_d      = ovr_q;
      if (byte_done) begin
         rx_valid_d = 1'b1;
         if (rx_valid_q) ovr_d = 1'b1;
      end else if (rx_ack && rx_valid_q) begin
         rx_valid_d = 1'b0;
         ovr_d      = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= WAIT_HI;
         settle_q   <= 2'd0;
         cnt_q      <= 3'd0;
         rx_sr_q    <= 7'd0;
         tx_sr_q    <= 8'd0;
         tx_buf_q   <= 8'hFF;
         data_out_q <= 8'h00;
         rx_valid_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         cnt_q      <= cnt_d;
         rx_sr_q    <= rx_sr_d;
         tx_sr_q    <= tx_sr_d;
         tx_buf_q   <= tx_buf_d;
         data_out_q <= data_out_d;
         rx_valid_q <= rx_valid_d;
         ovr_q      <= ovr_d;
      end
   end

   assign miso      = (state_q == SHIFT) & tx_sr_q[7];
   assign data_out  = data_out_q;
   assign rx_valid  = rx_valid_q;
   assign fsm_state = state_q;

`ifdef SPI_SLAVE_OVERRUN_EN
   assign rx_ovr = ovr_q;
`else
   // Overwrites stay silent in this build; the flag has no observer.
   logic ovr_unused;
   assign ovr_unused = ovr_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives spi_slave as an SPI mode-0 master; received bytes are
// checked by a monitor against an expected queue, returned bytes against a
// model of the transmit buffer.
`timescale 1ns/1ps
module tb_spi_slave;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst, scl, cs, mosi, miso, tx_load, rx_valid, rx_ack;
   logic [7:0] tx_data, data_out;
   logic [1:0] fsm_state;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       rx_ovr;
`endif

   spi_slave #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .scl(scl), .cs(cs), .mosi(mosi), .miso(miso),
      .tx_data(tx_data), .tx_load(tx_load), .data_out(data_out),
      .rx_valid(rx_valid), .rx_ack(rx_ack),
`ifdef SPI_SLAVE_OVERRUN_EN
      .rx_ovr(rx_ovr),
`endif
      .fsm_state(fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_tx_buf;   // what the slave will send on its next reload
   logic [7:0] exp_miso;       // what the slave sends in the current byte
   time        last8_time;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_tx(input logic [7:0] b);
      @(negedge clk);
      tx_data = b;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      model_tx_buf = b;
   endtask

   task automatic cs_low();
      @(negedge clk);
      cs = 1'b0;
      exp_miso = model_tx_buf;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_high();
      @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
      check("miso_idle", miso, 1'b0);
   endtask

   // Shifts nbits of tx out on mosi, collecting miso at each scl rise.
   task automatic xfer_byte(input logic [7:0] tx, input int nbits, input bit push);
      logic [7:0] got;
      logic [7:0] next_miso;
      got = 8'h00;
      next_miso = model_tx_buf;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         mosi = tx[7-i];
         repeat (3) @(negedge clk);
         scl = 1'b1;
         got = {got[6:0], miso};
         if (i == 7) begin
            last8_time = $time;
            next_miso  = model_tx_buf;
            if (push) exp_q.push_back(tx);
         end
         repeat (4) @(negedge clk);
         scl = 1'b0;
      end
      if (nbits == 8) begin
         check("miso_byte", got, exp_miso);
         exp_miso = next_miso;
      end
   endtask

   task automatic do_ack();
      repeat (2) @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      check("ack_clears_valid", rx_valid, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b1;
      model_tx_buf = 8'hFF;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic       prev_v;
      logic [7:0] e;
      int         lat;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1 && prev_v !== 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rx_valid", rx_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("rx_byte", data_out, e);
               lat = int'(($time - last8_time) / 10);
               check("rx_latency_ok", (lat <= SYNC + 2), 1'b1);
            end
         end
         prev_v = rx_valid;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int nb;
      rst = 1'b0; scl = 1'b0; cs = 1'b1; mosi = 1'b0;
      tx_load = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
      model_tx_buf = 8'hFF;
      exp_miso = 8'hFF;
      last8_time = 0;

      // Reset values
      repeat (2) @(negedge clk);
      check("reset_miso", miso, 1'b0);
      check("reset_data_out", data_out, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
      check("reset_rx_ovr", rx_ovr, 1'b0);
`endif
      rst = 1'b1;
      repeat (6) @(negedge clk);

      // Frame without any tx_load returns the reset buffer value
      cs_low();
      xfer_byte(8'h3B, 8, 1'b1);
      do_ack();
      cs_high();

      // Single frame with a loaded reply
      load_tx(8'h5C);
      cs_low();
      xfer_byte(8'hDA, 8, 1'b1);
      check("single_data_out", data_out, 8'hDA);
      do_ack();
      cs_high();

      // Back-to-back bytes under continuous cs low; load during SHIFT
      load_tx(8'hC3);
      cs_low();
      load_tx(8'h96);
      xfer_byte(8'hA5, 8, 1'b1);
      do_ack();
      xfer_byte(8'h3C, 8, 1'b1);
      check("b2b_data_out", data_out, 8'h3C);
      do_ack();
      cs_high();

      // Abort after 5 bits
      cs_low();
      xfer_byte(8'hFF, 5, 1'b0);
      cs_high();
      check("abort_rx_valid", rx_valid, 1'b0);
      check("abort_data_out", data_out, 8'h3C);
      cs_low();
      xfer_byte(8'h81, 8, 1'b1);
      do_ack();
      cs_high();
      check("post_abort_data_out", data_out, 8'h81);

      // Overrun: two frames without acknowledge
      cs_low();
      xfer_byte(8'h11, 8, 1'b1);
      cs_high();
      cs_low();
      xfer_byte(8'h22, 8, 1'b0);
      cs_high();
      check("ovr_data_out", data_out, 8'h22);
      check("ovr_rx_valid", rx_valid, 1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
      check("ovr_flag_set", rx_ovr, 1'b1);
`endif
      do_ack();
`ifdef SPI_SLAVE_OVERRUN_EN
      check("ovr_flag_cleared", rx_ovr, 1'b0);
`endif
      // Ack while nothing is pending is ignored
      do_ack();
      check("idle_ack_data_out", data_out, 8'h22);

      // Reset mid-frame with cs held low
      cs_low();
      xfer_byte(8'($urandom_range(0, 255)), 4, 1'b0);
      do_reset(2);
      xfer_byte(8'($urandom_range(0, 255)), 4, 1'b0);
      repeat (6) @(negedge clk);
      check("rst_mid_rx_valid", rx_valid, 1'b0);
      check("rst_mid_data_out", data_out, 8'h00);
      cs_high();
      cs_low();
      xfer_byte(8'h7E, 8, 1'b1);
      check("rst_mid_next_data_out", data_out, 8'h7E);
      do_ack();
      cs_high();

      // Randomised frames, including loads between back-to-back bytes
      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 1) == 1) load_tx(8'($urandom_range(0, 255)));
         nb = int'($urandom_range(1, 3));
         cs_low();
         for (int b = 0; b < nb; b++) begin
            xfer_byte(8'($urandom_range(0, 255)), 8, 1'b1);
            do_ack();
            if ($urandom_range(0, 3) == 0) load_tx(8'($urandom_range(0, 255)));
         end
         cs_high();
      end

      repeat (10) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
